// File: rtl/square_envelope.sv
// ADSR amplitude envelope for the square-wave oscillator output.
// Level steps only on tick; gate edges drive the phase machine and scale the sample stream.
//
// state   | meaning
// --------+---------------------------------------------
// IDLE    | silent, level held at 0
// ATTACK  | level rises by attack_step per tick to full scale
// DECAY   | level falls by decay_step per tick to sustain_level
// SUSTAIN | level tracks sustain_level on every tick
// RELEASE | level falls by release_step per tick to 0
module square_envelope #(
  parameter int LEVEL_W  = 16,
  parameter int SAMPLE_W = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       gate,
  input  logic                       tick,
  input  logic [LEVEL_W-1:0]         attack_step,
  input  logic [LEVEL_W-1:0]         decay_step,
  input  logic [LEVEL_W-1:0]         sustain_level,
  input  logic [LEVEL_W-1:0]         release_step,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic [LEVEL_W-1:0]         level,
  output logic [2:0]                 state,
  output logic                       busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  localparam logic [LEVEL_W-1:0] FULL_SCALE = '1;

  state_t                       state_q, state_d;
  logic [LEVEL_W-1:0]           level_q, level_d;
  logic                         gate_d;
  logic signed [SAMPLE_W-1:0]   sample_q, sample_d;
  logic                         gate_rise, gate_fall;
  logic [LEVEL_W:0]             atk_sum;
  logic signed [LEVEL_W:0]      dec_diff, rel_diff;
  logic signed [SAMPLE_W+LEVEL_W-1:0] prod;

  assign gate_rise = gate & ~gate_d;
  assign gate_fall = ~gate & gate_d;

  assign atk_sum  = {1'b0, level_q} + {1'b0, attack_step};
  assign dec_diff = $signed({1'b0, level_q}) - $signed({1'b0, decay_step});
  assign rel_diff = $signed({1'b0, level_q}) - $signed({1'b0, release_step});

  // Gain is strictly below 1, so the product always fits and the shift cannot overflow.
  assign prod     = $signed(sample_in) * $signed({1'b0, level_q});
  assign sample_d = SAMPLE_W'(prod >>> LEVEL_W);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      level_q  <= '0;
      gate_d   <= 1'b0;
      sample_q <= '0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      gate_d   <= gate;
      sample_q <= sample_d;
    end
  end

  // Edges win over tick: an edge cycle only moves the phase and holds the level.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (gate_rise) begin
      state_d = S_ATTACK;
    end else if (gate_fall) begin
      if (state_q == S_ATTACK || state_q == S_DECAY || state_q == S_SUSTAIN)
        state_d = S_RELEASE;
    end else if (tick) begin
      case (state_q)
        S_IDLE: level_d = '0;
        S_ATTACK: begin
          if (attack_step == '0 || atk_sum >= {1'b0, FULL_SCALE}) begin
            level_d = FULL_SCALE;
            state_d = S_DECAY;
          end else begin
            level_d = atk_sum[LEVEL_W-1:0];
          end
        end
        S_DECAY: begin
          if (decay_step == '0 || dec_diff <= $signed({1'b0, sustain_level})) begin
            level_d = sustain_level;
            state_d = S_SUSTAIN;
          end else begin
            level_d = dec_diff[LEVEL_W-1:0];
          end
        end
        S_SUSTAIN: level_d = sustain_level;
        S_RELEASE: begin
          if (release_step == '0 || rel_diff[LEVEL_W] || rel_diff == '0) begin
            level_d = '0;
            state_d = S_IDLE;
          end else begin
            level_d = rel_diff[LEVEL_W-1:0];
          end
        end
        default: begin
          level_d = '0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    sample_out = sample_q;
    level      = level_q;
    state      = state_q;
    busy       = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_square_envelope.sv
// Scoreboard bench for square_envelope: a behavioural model queues the expected
// outputs for each driven cycle, which are popped and compared after the clock edge.
module tb_square_envelope;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               gate = 1'b0;
  logic               tick = 1'b0;
  logic [15:0]        attack_step = '0;
  logic [15:0]        decay_step = '0;
  logic [15:0]        sustain_level = '0;
  logic [15:0]        release_step = '0;
  logic signed [31:0] sample_in = '0;
  logic signed [31:0] sample_out;
  logic [15:0]        level;
  logic [2:0]         state;
  logic               busy;

  square_envelope #(.LEVEL_W(16), .SAMPLE_W(32)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .gate          (gate),
    .tick          (tick),
    .attack_step   (attack_step),
    .decay_step    (decay_step),
    .sustain_level (sustain_level),
    .release_step  (release_step),
    .sample_in     (sample_in),
    .sample_out    (sample_out),
    .level         (level),
    .state         (state),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int lv;
    int so;
    int bz;
  } exp_t;

  exp_t sb[$];
  int   errs = 0;
  int   checks = 0;
  int   m_st = 0;
  int   m_lv = 0;
  int   m_gd = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errs++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  task automatic cyc(input bit tk);
    exp_t   e;
    longint p;
    int     d;
    tick = tk;
    if (!reset_n) begin
      m_st = 0; m_lv = 0; m_gd = 0; e.so = 0;
    end else begin
      p    = longint'(sample_in) * longint'(m_lv);
      e.so = int'(p >>> 16);
      if (gate && m_gd == 0) begin
        m_st = 1;
      end else if (!gate && m_gd == 1) begin
        if (m_st >= 1 && m_st <= 3) m_st = 4;
      end else if (tk) begin
        case (m_st)
          0: m_lv = 0;
          1: begin
            d = m_lv + int'(attack_step);
            if (attack_step == 0 || d >= 65535) begin m_lv = 65535; m_st = 2; end
            else m_lv = d;
          end
          2: begin
            d = m_lv - int'(decay_step);
            if (decay_step == 0 || d <= int'(sustain_level)) begin m_lv = int'(sustain_level); m_st = 3; end
            else m_lv = d;
          end
          3: m_lv = int'(sustain_level);
          default: begin
            d = m_lv - int'(release_step);
            if (release_step == 0 || d <= 0) begin m_lv = 0; m_st = 0; end
            else m_lv = d;
          end
        endcase
      end
      m_gd = gate ? 1 : 0;
    end
    e.st = m_st;
    e.lv = m_lv;
    e.bz = (m_st != 0) ? 1 : 0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    tick = 1'b0;
    if (sb.size() == 0) begin
      chk("sb_underflow", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("sb_state", longint'(state), longint'(e.st));
      chk("sb_level", longint'(level), longint'(e.lv));
      chk("sb_sample", longint'(sample_out), longint'(e.so));
      chk("sb_busy", longint'(busy), longint'(e.bz));
    end
  endtask

  task automatic tick4();
    repeat (3) cyc(1'b0);
    cyc(1'b1);
  endtask

  int atk_lv[4];
  int rel_lv[4];

  initial begin
    atk_lv = '{32'h4000, 32'h8000, 32'hC000, 32'hFFFF};
    rel_lv = '{32'h6000, 32'h4000, 32'h2000, 32'h0};

    cyc(1'b0);
    cyc(1'b1);
    chk("rst_state", longint'(state), 0);
    chk("rst_level", longint'(level), 0);
    chk("rst_busy", longint'(busy), 0);
    reset_n = 1'b1;
    cyc(1'b1);
    chk("idle_tick_level", longint'(level), 0);

    // attack to saturation
    sample_in   = 32'sd1 <<< 20;
    attack_step = 16'h4000;
    gate        = 1'b1;
    cyc(1'b0);
    chk("atk_enter", longint'(state), 1);
    for (int i = 0; i < 4; i++) begin
      tick4();
      chk($sformatf("atk_lv%0d", i), longint'(level), longint'(atk_lv[i]));
    end
    chk("atk_to_decay", longint'(state), 2);
    cyc(1'b0);
    chk("full_pos", longint'(sample_out), 1048560);
    sample_in = -(32'sd1 <<< 20);
    cyc(1'b0);
    chk("full_neg", longint'(sample_out), -1048560);

    // decay into sustain
    sample_in     = 32'sd1 <<< 20;
    decay_step    = 16'h1000;
    sustain_level = 16'h8000;
    repeat (7) tick4();
    chk("dec_7", longint'(level), 32'h8FFF);
    chk("dec_7_state", longint'(state), 2);
    tick4();
    chk("dec_8", longint'(level), 32'h8000);
    chk("sus_state", longint'(state), 3);
    cyc(1'b0);
    chk("sus_sample", longint'(sample_out), 524288);

    // release to idle
    release_step = 16'h2000;
    gate = 1'b0;
    cyc(1'b0);
    chk("rel_enter", longint'(state), 4);
    for (int i = 0; i < 4; i++) begin
      tick4();
      chk($sformatf("rel_lv%0d", i), longint'(level), longint'(rel_lv[i]));
    end
    chk("rel_idle", longint'(state), 0);
    chk("rel_busy", longint'(busy), 0);
    cyc(1'b0);
    chk("rel_sample", longint'(sample_out), 0);

    // retrigger in RELEASE coinciding with tick
    gate = 1'b1;
    attack_step = 16'h3000;
    cyc(1'b0);
    cyc(1'b1);
    gate = 1'b0;
    cyc(1'b0);
    chk("rt_rel", longint'(state), 4);
    gate = 1'b1;
    cyc(1'b1);
    chk("rt_state", longint'(state), 1);
    chk("rt_hold", longint'(level), 32'h3000);
    attack_step = 16'h1000;
    cyc(1'b1);
    chk("rt_step", longint'(level), 32'h4000);

    // zero steps are instant
    attack_step = 16'h0;
    cyc(1'b1);
    chk("z_atk", longint'(level), 32'hFFFF);
    chk("z_atk_st", longint'(state), 2);
    decay_step = 16'h0;
    cyc(1'b1);
    chk("z_dec", longint'(level), 32'h8000);
    chk("z_dec_st", longint'(state), 3);
    gate = 1'b0;
    release_step = 16'h0;
    cyc(1'b0);
    cyc(1'b1);
    chk("z_rel", longint'(level), 0);
    chk("z_rel_st", longint'(state), 0);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ((i % 16) == 0) begin
        attack_step   = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
        decay_step    = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom_range(0, 16'h3000));
        release_step  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom_range(0, 16'h3000));
        sustain_level = 16'($urandom);
      end
      if ($urandom_range(0, 11) == 0) gate = ~gate;
      sample_in = $signed(32'($urandom));
      cyc($urandom_range(0, 2) == 0);
    end

    // async reset mid-attack at 0x8000, gate held high across release
    gate = 1'b0;
    reset_n = 1'b0;
    cyc(1'b0);
    reset_n = 1'b1;
    sample_in = 32'sd1 <<< 20;
    attack_step = 16'h4000;
    gate = 1'b1;
    cyc(1'b0);
    cyc(1'b1);
    cyc(1'b1);
    cyc(1'b0);
    chk("pre_rst_level", longint'(level), 32'h8000);
    chk("pre_rst_state", longint'(state), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_state", longint'(state), 0);
    chk("arst_level", longint'(level), 0);
    chk("arst_sample", longint'(sample_out), 0);
    chk("arst_busy", longint'(busy), 0);
    m_st = 0; m_lv = 0; m_gd = 0;
    cyc(1'b0);
    reset_n = 1'b1;
    cyc(1'b0);
    chk("rise_after_rst", longint'(state), 1);
    cyc(1'b1);
    chk("atk_after_rst", longint'(level), 32'h4000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/square_envelope.md
Name: square_envelope

Overview:
- ADSR amplitude envelope directly downstream of the square-wave oscillator; consumes its 32-bit signed sample stream every clock and emits the gain-scaled sample to the mixer/audio output.
- Envelope level advances only on a `tick` strobe (envelope-rate enable); a `gate` input (note on/off) drives the state machine.

Parameters:
- LEVEL_W, 16, envelope level / step width; full scale = 2^LEVEL_W-1 (0xFFFF).
- SAMPLE_W, 32, signed sample width in and out.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- gate  in  1  note on (1) / off (0); level, edge-detected internally.
- tick  in  1  envelope update strobe, one clk wide.
- attack_step  in  LEVEL_W  level increment per tick in ATTACK; 0 = instant.
- decay_step  in  LEVEL_W  level decrement per tick in DECAY; 0 = instant.
- sustain_level  in  LEVEL_W  sustain target.
- release_step  in  LEVEL_W  level decrement per tick in RELEASE; 0 = instant.
- sample_in  in  SAMPLE_W  signed oscillator sample, valid every clk.
- sample_out  out  SAMPLE_W  signed scaled sample.
- level  out  LEVEL_W  current envelope level.
- state  out  3  0 IDLE, 1 ATTACK, 2 DECAY, 3 SUSTAIN, 4 RELEASE.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, level=0, sample_out=0, gate_d=0, busy=0.
- gate_d = gate registered each clk. Rise = gate & !gate_d; fall = !gate & gate_d. Gate high across reset release -> rise seen on first clk.
- Priority per clk: rise > fall > tick. On an edge cycle the state changes, level is held, and a coincident tick is dropped.
- Rise from any state (including RELEASE/ATTACK) -> ATTACK. Retrigger keeps the current level; no reset to 0.
- Fall in ATTACK/DECAY/SUSTAIN -> RELEASE. Fall in IDLE or RELEASE: no effect.
- On tick:
  - IDLE: hold level=0.
  - ATTACK: sum = level+attack_step, computed LEVEL_W+1 wide.
    - sum >= 0xFFFF or step = 0 -> level=0xFFFF, go to DECAY.
    - Otherwise level=sum.
  - DECAY: diff = level-decay_step, signed, computed LEVEL_W+1 wide.
    - diff <= sustain_level or step = 0 -> level=sustain_level, go to SUSTAIN.
    - Otherwise level=diff.
  - SUSTAIN: level=sustain_level, so live changes apply on the next tick.
  - RELEASE: diff = level-release_step.
    - diff <= 0 or step = 0 -> level=0, go to IDLE.
    - Otherwise level=diff.
- sample_out (registered, latency 1 clk) = (sample_in * {0,level}) >>> LEVEL_W.
  - Signed 48-bit product, arithmetic shift, truncated to SAMPLE_W.
  - Uses the level register value of the same cycle, before its update.
- No overflow possible: the gain is < 1.
- Steps and sustain_level are sampled only when used; they may change at any time.

Test Plan:
- Reset: assert reset_n=0 mid-ATTACK at level 0x8000 -> immediately state=0, level=0, sample_out=0, busy=0.
- Attack saturate: sample_in=1<<20, attack_step=0x4000, gate 0->1, tick every 4 clk.
  - Levels 0x4000, 0x8000, 0xC000, 0xFFFF; state=DECAY after the 4th tick.
  - At 0xFFFF, sample_out=0x000FFFF0 (1048560); with sample_in=-(1<<20), -1048560.
- Decay/sustain: decay_step=0x1000, sustain_level=0x8000 from 0xFFFF.
  - 7 ticks reach 0x8FFF; 8th tick -> level=0x8000, state=SUSTAIN.
  - sample_out=524288 for sample_in=1<<20, one clk after the level update.
- Release: gate 1->0 in SUSTAIN at 0x8000, release_step=0x2000.
  - Levels 0x6000, 0x4000, 0x2000, 0 over 4 ticks; state=IDLE, busy=0, sample_out=0.
- Edge vs tick: gate rise in RELEASE at level 0x3000 coinciding with tick -> state=ATTACK, level stays 0x3000; next tick with attack_step=0x1000 -> 0x4000.
- Zero steps: attack_step=0 -> one tick gives level=0xFFFF/DECAY; decay_step=0 -> next tick gives sustain; release_step=0 -> level 0/IDLE in one tick.
